// File: rtl/fpu_pkg.sv
// Types and widths shared between the FPU core and its operand sequencer.
// Word layout: sign [31], exponent [30:25], mantissa [24:0].
package fpu_pkg;

  localparam int unsigned EXP_W  = 6;
  localparam int unsigned MANT_W = 25;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [3:0] {
    StatusExact     = 4'b0001,
    StatusInexact   = 4'b0010,
    StatusOverflow  = 4'b0100,
    StatusUnderflow = 4'b1000
  } status_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHold,
    StCapture,
    StOutput
  } seq_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
  } op_pair_t;

  function automatic logic [EXP_W-1:0] word_exp(input logic [WORD_W-1:0] w);
    return w[WORD_W-2 -: EXP_W];
  endfunction

  function automatic logic [MANT_W-1:0] word_mant(input logic [WORD_W-1:0] w);
    return w[MANT_W-1:0];
  endfunction

endpackage

// File: rtl/fpu_pair_fifo.sv
// DEPTH-entry synchronous FIFO for operand pairs. Full/empty come from the
// registered count, so a push on a full FIFO is refused even if a pop happens.
module fpu_pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q;
  logic               push_ok, pop_ok;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Feeds buffered operand pairs to the free-running FPU, restarts it, waits out
// the hold window and returns the captured result over a valid/ready handshake.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 80
) (
  input  logic                    clock100KHz,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       in_op_a,
  input  logic [WORD_W-1:0]       in_op_b,
  output logic [WORD_W-1:0]       fpu_op_a,
  output logic [WORD_W-1:0]       fpu_op_b,
  output logic                    fpu_rst_n,
  input  logic [WORD_W-1:0]       fpu_data,
  input  logic [3:0]              fpu_status,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WORD_W-1:0]       res_data,
  output logic [3:0]              res_status,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  seq_state_t        state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  op_pair_t          pair_q, fifo_rdata;
  logic              fifo_full, fifo_empty, pop, capture;

  fpu_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(op_pair_t))
  ) u_fifo (
    .clk   (clock100KHz),
    .rst   (reset),
    .push  (in_valid && in_ready),
    .wdata ({in_op_a, in_op_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q != StIdle);
  assign fpu_op_a = pair_q.op_a;
  assign fpu_op_b = pair_q.op_b;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = StHold;
        hold_d  = HoldW'(HOLD_CYCLES - 1);
      end
      StHold: begin
        if (hold_q == '0) state_d = StCapture;
        else              hold_d  = hold_q - 1'b1;
      end
      StCapture: begin
        capture = 1'b1;
        state_d = StOutput;
      end
      StOutput: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      pair_q     <= '0;
      fpu_rst_n  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_status <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      // Registered so the FPU sees a clean, glitch-free one-cycle restart pulse.
      fpu_rst_n <= (state_d != StLoad);
      if (pop) pair_q <= fifo_rdata;
      if (capture) begin
        res_data   <= fpu_data;
        res_status <= fpu_status;
        res_valid  <= 1'b1;
      end else if (state_q == StOutput && res_ready) begin
        res_valid  <= 1'b0;
      end
    end
  end

endmodule
